// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding/hazard unit (package fwd_pkg).
// Stage entries keep dst zero-extended to FWD_DST_W bits, so one struct serves every REG_ADDR_W up to 8.
package fwd_pkg;

  localparam int FWD_DST_W  = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [FWD_DST_W-1:0] dst;
    logic                 wr_en;
    logic                 is_load;
  } fwd_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage bundle between the pipeline and the forwarding/hazard unit.
// stall_cnt exists only when FWD_PERF_CNT_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2
);
  import fwd_pkg::*;

  localparam int SEL_W = sel_w(DEPTH);

  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [REG_ADDR_W-1:0]         id_dst;
  logic                          id_wr_en;
  logic                          id_is_load;
  logic                          flush;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
`ifdef FWD_PERF_CNT_EN
  logic [15:0]                   stall_cnt;
`endif

  modport master (
    output id_valid, id_src, id_dst, id_wr_en, id_is_load, flush,
    input  fwd_sel, stall
`ifdef FWD_PERF_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_src, id_dst, id_wr_en, id_is_load, flush,
    output fwd_sel, stall
`ifdef FWD_PERF_CNT_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// One source operand against all tracked stages: youngest-producer select plus load-hit flag.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int DEPTH      = 2,
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = 2
) (
  input  logic [REG_ADDR_W-1:0]   src,
  input  fwd_entry_t [DEPTH-1:0]  stages,
  output logic [SEL_W-1:0]        sel,
  output logic                    load_hit
);

  logic             src_zero;
  logic [DEPTH-1:0] hit;

  assign src_zero = (ZERO_REG != 0) && (src == '0);

  always_comb begin
    hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = stages[k].valid && stages[k].wr_en && !src_zero &&
               (stages[k].dst == FWD_DST_W'(src));
    end
  end

  // Walk oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    sel      = SEL_W'(FWD_SEL_RF);
    load_hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < LOAD_STALL) && hit[k] && stages[k].is_load) load_hit = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadow pipeline of in-flight writes, per-source forward select.
// Optional stall-cycle counter enabled by FWD_PERF_CNT_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
);

  localparam int SEL_W = sel_w(DEPTH);

  fwd_entry_t [DEPTH-1:0]            stage_q;
  logic [NUM_SRC-1:0][SEL_W-1:0]     sel_raw;
  logic [NUM_SRC-1:0]                load_hit;
  logic                              stall;
  fwd_entry_t                        id_entry;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (DEPTH),
      .LOAD_STALL (LOAD_STALL),
      .ZERO_REG   (ZERO_REG),
      .SEL_W      (SEL_W)
    ) u_match (
      .src      (bus.id_src[i*REG_ADDR_W +: REG_ADDR_W]),
      .stages   (stage_q),
      .sel      (sel_raw[i]),
      .load_hit (load_hit[i])
    );
  end

  assign stall       = bus.id_valid && !bus.flush && (|load_hit);
  assign bus.stall   = stall;
  assign bus.fwd_sel = bus.id_valid ? sel_raw : '0;

  assign id_entry = '{valid:   1'b1,
                      dst:     FWD_DST_W'(bus.id_dst),
                      wr_en:   bus.id_wr_en,
                      is_load: bus.id_is_load};

  // Older stages keep advancing during a stall; only stage 1 takes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (bus.flush) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= (stall || !bus.id_valid) ? fwd_entry_t'('0) : id_entry;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic against a list-based reference model.
module tb_fwd_hazard_unit;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_SRC    = 2;
  localparam int DEPTH      = 2;
  localparam int LOAD_STALL = 1;
  localparam int SEL_W      = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;

  fwd_hazard_unit_if #(.REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

  fwd_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC),
    .DEPTH      (DEPTH),
    .LOAD_STALL (LOAD_STALL),
    .ZERO_REG   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: in-flight list, position 1 = youngest.
  int m_v   [1:DEPTH];
  int m_dst [1:DEPTH];
  int m_wr  [1:DEPTH];
  int m_ld  [1:DEPTH];
  int m_cnt;

  logic [31:0] got_s0, got_s1, got_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      m_v[k] = 0; m_dst[k] = 0; m_wr[k] = 0; m_ld[k] = 0;
    end
  endfunction

  function automatic int model_sel(input int src);
    if (src == 0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (m_v[k] != 0 && m_wr[k] != 0 && m_dst[k] == src) return k;
    return 0;
  endfunction

  function automatic bit model_load_use(input int src);
    if (src == 0) return 0;
    for (int k = 1; k <= LOAD_STALL; k++)
      if (m_v[k] != 0 && m_wr[k] != 0 && m_ld[k] != 0 && m_dst[k] == src) return 1;
    return 0;
  endfunction

  task automatic step(input bit v, input int s0, input int s1, input int d,
                      input bit wr, input bit ld, input bit fl);
    int  e0, e1;
    bit  es;
    @(negedge clk);
    bus.id_valid   = v;
    bus.id_src     = {REG_ADDR_W'(s1), REG_ADDR_W'(s0)};
    bus.id_dst     = REG_ADDR_W'(d);
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.flush      = fl;
    #1;
    e0 = v ? model_sel(s0) : 0;
    e1 = v ? model_sel(s1) : 0;
    es = v && !fl && (model_load_use(s0) || model_load_use(s1));
    got_s0 = 32'(bus.fwd_sel[0 +: SEL_W]);
    got_s1 = 32'(bus.fwd_sel[SEL_W +: SEL_W]);
    got_st = 32'(bus.stall);
    chk("fwd_sel0", got_s0, e0);
    chk("fwd_sel1", got_s1, e1);
    chk("stall", got_st, 32'(es));
`ifdef FWD_PERF_CNT_EN
    chk("stall_cnt", 32'(bus.stall_cnt), m_cnt);
`endif
    @(posedge clk);
    if (es && m_cnt != 65535) m_cnt++;
    if (fl) begin
      model_clear();
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_dst[k] = m_dst[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
      end
      if (es || !v) begin
        m_v[1] = 0; m_dst[1] = 0; m_wr[1] = 0; m_ld[1] = 0;
      end else begin
        m_v[1] = 1; m_dst[1] = d; m_wr[1] = wr; m_ld[1] = ld;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_src = '0; bus.id_dst = '0;
    bus.id_wr_en = 0; bus.id_is_load = 0; bus.flush = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    m_cnt = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    // Reset state: valid reads of nonzero registers all come from the regfile.
    step(1, 3, 5, 1, 1, 1, 0);
    chk("reset_sel0", got_s0, 0);
    chk("reset_stall", got_st, 0);

    // ALU chain: immediate consumer forwards from stage 1, after a bubble from stage 2.
    step(1, 0, 0, 3, 1, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    chk("alu_chain_s1", got_s0, 1);
    chk("alu_chain_nostall", got_st, 0);
    step(1, 0, 0, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    chk("alu_chain_s2", got_s0, 2);

    // Priority: r5 in both stages, youngest wins.
    step(1, 0, 0, 5, 1, 0, 0);
    step(1, 0, 0, 5, 1, 0, 0);
    step(1, 0, 5, 0, 0, 0, 0);
    chk("priority_sel1", got_s1, 1);

    // Load-use: exactly one stall cycle, then forward from stage 2.
    step(1, 0, 0, 2, 1, 1, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    chk("load_use_stall", got_st, 1);
    step(1, 2, 0, 0, 0, 0, 0);
    chk("load_use_release", got_st, 0);
    chk("load_use_fwd", got_s0, 2);

    // Zero register is never forwarded, even from a load.
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("zero_reg_sel", got_s0, 0);
    chk("zero_reg_stall", got_st, 0);

    // Flush with a pending load-use hazard.
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 4, 1, 1, 0);
    step(1, 4, 1, 0, 0, 0, 1);
    chk("flush_stall", got_st, 0);
    step(1, 1, 4, 0, 0, 0, 0);
    chk("flush_sel0", got_s0, 0);
    chk("flush_sel1", got_s1, 0);

    // Asynchronous reset while stalled.
    step(1, 0, 0, 6, 1, 1, 0);
    @(negedge clk);
    bus.id_valid = 1; bus.id_src = {3'd0, 3'd6}; bus.id_wr_en = 0; bus.id_is_load = 0;
    #1;
    chk("pre_reset_stall", 32'(bus.stall), 1);
    rst_n = 0;
    #1;
    chk("async_rst_stall", 32'(bus.stall), 0);
    chk("async_rst_sel0", 32'(bus.fwd_sel[0 +: SEL_W]), 0);
`ifdef FWD_PERF_CNT_EN
    chk("async_rst_cnt", 32'(bus.stall_cnt), 0);
`endif
    model_clear();
    m_cnt = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;

`ifdef FWD_PERF_CNT_EN
    for (int n = 0; n < 3; n++) begin
      step(1, 0, 0, 7, 1, 1, 0);
      step(1, 0, 7, 0, 0, 0, 0);
      step(1, 0, 7, 0, 0, 0, 0);
    end
    @(negedge clk);
    #1;
    chk("perf_three_stalls", 32'(bus.stall_cnt), 3);
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 85,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
